fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer between the PC register and the instruction cache's SRAM-like port. Issues one aligned 64-bit fetch per PC and drives `stallF_o` so the PC advances only on a delivered fetch or a flush. Discards responses made stale by a redirect, and presents up to two instructions to decode through a one-entry output register plus one skid entry.

## Interface
Parameters: none.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_i  in  32  current PC from PC register
- flush_i  in  1  redirect this cycle (trap, mispredict, jump, predicted-taken branch); PC register loads the target at this edge
- stallF_o  out  1  hold PC register
- inst_req_o  out  1  fetch request
- inst_addr_o  out  32  fetch address, bits [2:0] = 0
- inst_addr_ok_i  in  1  request accepted
- inst_data_ok_i  in  1  response valid
- inst_rdata_i  in  64  [31:0] = word at addr, [63:32] = word at addr+4
- ifid_valid_o  out  1  fetch packet valid
- ifid_ready_i  in  1  decode consumes packet this cycle
- ifid_pc_o  out  32  PC of inst0
- ifid_inst0_o  out  32  first instruction
- ifid_inst1_o  out  32  second instruction (pc+4)
- ifid_inst1_valid_o  out  1  inst1 usable (= ~pc[2])

## Operation
- States: IDLE, ADDR, DATA, CANCEL, FULL. Reset: IDLE.
  - Reset outputs: inst_req_o=0, ifid_valid_o=0, stallF_o=1.
  - All other regs and outputs: 0.
- IDLE → ADDR unconditionally.
- ADDR: inst_req_o=1.
  - inst_addr_o = {pc_i[31:3],3'b0} in the first ADDR cycle. If addr_ok is absent, the address is latched into `req_addr` and held until addr_ok, even if pc_i changes.
  - addr_ok → DATA. `req_pc` latches the issued PC.
  - Flush in ADDR sets `kill`. addr_ok with kill or flush_i → CANCEL.
- DATA, on data_ok with no kill and no flush_i (good response):
  - If ~ifid_valid_o | ifid_ready_i: load the output register, → ADDR.
  - Otherwise: load the skid entry, → FULL.
- DATA, on data_ok with kill or flush_i: discard the response, → ADDR.
- DATA, flush_i without data_ok → CANCEL.
- CANCEL: wait for data_ok, discard it, clear kill, → ADDR.
- FULL: on ifid_ready_i, move skid to output, → ADDR. Flush → clear skid, → ADDR.
- Packet contents:
  - ifid_inst0_o = pc[2] ? rdata[63:32] : rdata[31:0]
  - ifid_inst1_o = rdata[63:32]
  - ifid_inst1_valid_o = ~pc[2]
- stallF_o = ~(good response accepted this cycle) & ~flush_i. flush_i always releases the PC, whatever the state.
- flush_i clears ifid_valid_o and the skid entry at the next edge. Flush wins over a simultaneous good response.
- ifid_valid_o clears on ifid_ready_i when nothing new is loaded.
- At most one request outstanding.

## Timing
- The cache never returns data_ok in the same cycle as addr_ok for the same request. data_ok comes ≥1 cycle later.
- Best case: addr_ok in the first ADDR cycle, data_ok one cycle later. That gives one packet per 2 cycles.
- PC update coincides with the data_ok edge. The next ADDR cycle sees the new pc_i.
- Decode sees a packet the cycle after data_ok.
- Reset mid-transaction: return to IDLE. Any late data_ok from before reset is ignored while in IDLE or ADDR.

## Configuration
- `FETCH_PERF_EN` defined: three extra 32-bit outputs, reset 0, wrap on overflow, flush-insensitive.
  - perf_fetch_o: good responses.
  - perf_cancel_o: discarded responses.
  - perf_stall_o: cycles with stallF_o=1.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `if_pkg`:
  - `fetch_state_t` enum.
  - `fetch_pkt_t` struct {pc, inst0, inst1, inst1_valid}.
  - Constant `FETCH_ALIGN_MASK` = 32'hffff_fff8.
- Sub-module `fetch_skid_buf`: one-entry `fetch_pkt_t` skid register with load/drain/clear controls.
- FSM, kill flag and address latch stay in `fetch_ctrl`.

## Test plan
- pc_i=bfc0_0000; addr_ok cycle 1, data_ok cycle 2, rdata=1111_1111_2222_2222 → inst0=2222_2222, inst1=1111_1111, inst1_valid=1, stallF_o=0 only in cycle 2.
- pc_i=bfc0_0004 → inst_addr_o=bfc0_0000, inst0=rdata[63:32], inst1_valid=0.
- flush_i in DATA before data_ok → CANCEL; next data_ok discarded, ifid_valid stays 0; new ADDR uses target pc.
- addr_ok withheld 3 cycles while flush_i changes pc_i → inst_addr_o held at original value; response discarded.
- ifid_ready_i=0 with valid output, good data_ok → skid filled, FULL, stallF_o=1; ready=1 → skid drains next cycle.
- flush_i and good data_ok same cycle → data dropped, ifid_valid_o=0; with `FETCH_PERF_EN`, perf_cancel_o increments by 1.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Used by fetch_ctrl and fetch_skid_buf.
package if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_CANCEL = 3'd3,
        ST_FULL   = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic        inst1_valid;
    } fetch_pkt_t;

    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hffff_fff8;

    // A PC with bit 2 set lands on the upper word, so only one instruction is usable.
    function automatic fetch_pkt_t make_pkt(input logic [31:0] pc, input logic [63:0] rdata);
        fetch_pkt_t pkt;
        pkt.pc          = pc;
        pkt.inst0       = pc[2] ? rdata[63:32] : rdata[31:0];
        pkt.inst1       = rdata[63:32];
        pkt.inst1_valid = ~pc[2];
        return pkt;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetch packet while decode is back-pressuring.
// clear has priority over load, load over drain.
module fetch_skid_buf
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       drain,
    input  logic       clear,
    input  fetch_pkt_t load_pkt,
    output logic       valid,
    output fetch_pkt_t pkt
);

    logic       valid_reg;
    fetch_pkt_t pkt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            pkt_reg   <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            pkt_reg   <= load_pkt;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign pkt   = pkt_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one aligned 64-bit fetch per PC, stale-response discard,
// output register plus skid entry toward decode. Define FETCH_PERF_EN for perf counters.
module fetch_ctrl
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        stallF_o,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [63:0] inst_rdata_i,
    output logic        ifid_valid_o,
    input  logic        ifid_ready_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_inst0_o,
    output logic [31:0] ifid_inst1_o,
    output logic        ifid_inst1_valid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_cancel_o,
    output logic [31:0] perf_stall_o
`endif
);

    fetch_state_t state_reg, state_next;
    logic         kill_reg, kill_next;
    logic         held_reg, held_next;
    logic [31:0]  req_pc_reg, req_pc_next;
    logic         out_valid_reg, out_valid_next;
    fetch_pkt_t   out_pkt_reg, out_pkt_next;

    logic [31:0]  issue_pc;
    logic         in_data, resp_good, resp_drop, to_out, to_skid, skid_drain, skid_valid;
    fetch_pkt_t   resp_pkt, skid_pkt;

    // Once a request has waited a cycle, the address is frozen until accepted.
    assign issue_pc   = held_reg ? req_pc_reg : pc_i;
    assign in_data    = (state_reg == ST_DATA);
    assign resp_good  = in_data & inst_data_ok_i & ~kill_reg & ~flush_i;
    assign resp_drop  = inst_data_ok_i & ((in_data & (kill_reg | flush_i)) | (state_reg == ST_CANCEL));
    assign to_out     = resp_good & (~out_valid_reg | ifid_ready_i);
    assign to_skid    = resp_good & ~to_out;
    assign skid_drain = (state_reg == ST_FULL) & ifid_ready_i & ~flush_i;
    assign resp_pkt   = make_pkt(req_pc_reg, inst_rdata_i);

    always_comb begin
        state_next  = state_reg;
        kill_next   = kill_reg;
        held_next   = held_reg;
        req_pc_next = req_pc_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_ADDR;
            ST_ADDR: begin
                req_pc_next = issue_pc;
                if (inst_addr_ok_i) begin
                    held_next  = 1'b0;
                    state_next = (kill_reg | flush_i) ? ST_CANCEL : ST_DATA;
                end else begin
                    held_next = 1'b1;
                    if (flush_i) kill_next = 1'b1;
                end
            end
            ST_DATA: begin
                if (inst_data_ok_i) begin
                    kill_next  = 1'b0;
                    state_next = to_skid ? ST_FULL : ST_ADDR;
                end else if (flush_i) begin
                    state_next = ST_CANCEL;
                end
            end
            ST_CANCEL: begin
                if (inst_data_ok_i) begin
                    kill_next  = 1'b0;
                    state_next = ST_ADDR;
                end
            end
            ST_FULL: if (flush_i | ifid_ready_i) state_next = ST_ADDR;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        out_pkt_next   = out_pkt_reg;
        if (flush_i) begin
            out_valid_next = 1'b0;
        end else if (to_out) begin
            out_valid_next = 1'b1;
            out_pkt_next   = resp_pkt;
        end else if (skid_drain) begin
            out_valid_next = 1'b1;
            out_pkt_next   = skid_pkt;
        end else if (ifid_ready_i) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            kill_reg      <= 1'b0;
            held_reg      <= 1'b0;
            req_pc_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_pkt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            kill_reg      <= kill_next;
            held_reg      <= held_next;
            req_pc_reg    <= req_pc_next;
            out_valid_reg <= out_valid_next;
            out_pkt_reg   <= out_pkt_next;
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (to_skid),
        .drain    (skid_drain),
        .clear    (flush_i),
        .load_pkt (resp_pkt),
        .valid    (skid_valid),
        .pkt      (skid_pkt)
    );

    assign stallF_o           = ~resp_good & ~flush_i;
    assign inst_req_o         = (state_reg == ST_ADDR);
    assign inst_addr_o        = issue_pc & FETCH_ALIGN_MASK;
    assign ifid_valid_o       = out_valid_reg;
    assign ifid_pc_o          = out_pkt_reg.pc;
    assign ifid_inst0_o       = out_pkt_reg.inst0;
    assign ifid_inst1_o       = out_pkt_reg.inst1;
    assign ifid_inst1_valid_o = out_pkt_reg.inst1_valid;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_reg, perf_cancel_reg, perf_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_reg  <= '0;
            perf_cancel_reg <= '0;
            perf_stall_reg  <= '0;
        end else begin
            perf_fetch_reg  <= perf_fetch_reg + {31'd0, resp_good};
            perf_cancel_reg <= perf_cancel_reg + {31'd0, resp_drop};
            perf_stall_reg  <= perf_stall_reg + {31'd0, stallF_o};
        end
    end

    assign perf_fetch_o  = perf_fetch_reg;
    assign perf_cancel_o = perf_cancel_reg;
    assign perf_stall_o  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized cache/decode traffic
// checked against a transaction-level model (PC register, cache latency, packet queue).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        stallF_o;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [63:0] inst_rdata_i;
    logic        ifid_valid_o;
    logic        ifid_ready_i;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_inst0_o;
    logic [31:0] ifid_inst1_o;
    logic        ifid_inst1_valid_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_o, perf_cancel_o, perf_stall_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        v1;
    } pkt_t;

    fetch_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .pc_i               (pc_i),
        .flush_i            (flush_i),
        .stallF_o           (stallF_o),
        .inst_req_o         (inst_req_o),
        .inst_addr_o        (inst_addr_o),
        .inst_addr_ok_i     (inst_addr_ok_i),
        .inst_data_ok_i     (inst_data_ok_i),
        .inst_rdata_i       (inst_rdata_i),
        .ifid_valid_o       (ifid_valid_o),
        .ifid_ready_i       (ifid_ready_i),
        .ifid_pc_o          (ifid_pc_o),
        .ifid_inst0_o       (ifid_inst0_o),
        .ifid_inst1_o       (ifid_inst1_o),
        .ifid_inst1_valid_o (ifid_inst1_valid_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o       (perf_fetch_o),
        .perf_cancel_o      (perf_cancel_o),
        .perf_stall_o       (perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pc_i = '0; flush_i = 0; inst_addr_ok_i = 0; inst_data_ok_i = 0;
        inst_rdata_i = '0; ifid_ready_i = 0;
    endtask

    // Leaves the DUT in its first ADDR cycle.
    task automatic do_reset();
        rst = 1; clear_inputs();
        step(); step();
        rst = 0;
        step();
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        step(); step();
        n_assert++; if (inst_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", inst_req_o); end
        n_assert++; if (ifid_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ifid_valid_o); end
        n_assert++; if (stallF_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", stallF_o); end
        n_assert++; if (ifid_pc_o !== 32'h0 || ifid_inst0_o !== 32'h0) begin n_fail++; $display("FAIL reset_pkt: got pc %h inst0 %h want 0", ifid_pc_o, ifid_inst0_o); end
        // reset mid-transaction, then a late data_ok in IDLE and ADDR
        rst = 0; pc_i = 32'h40; step();
        inst_addr_ok_i = 1; step();
        inst_addr_ok_i = 0; rst = 1; step();
        rst = 0; inst_data_ok_i = 1; inst_rdata_i = 64'hdead_beef_cafe_f00d; #1;
        n_assert++; if (stallF_o !== 1'b1) begin n_fail++; $display("FAIL late_ok_idle_stall: got %b want 1", stallF_o); end
        step();
        pc_i = 32'h80; #1;
        n_assert++; if (stallF_o !== 1'b1) begin n_fail++; $display("FAIL late_ok_addr_stall: got %b want 1", stallF_o); end
        n_assert++; if (inst_addr_o !== 32'h80) begin n_fail++; $display("FAIL late_ok_addr: got %h want 00000080", inst_addr_o); end
        inst_data_ok_i = 0; step();
        n_assert++; if (ifid_valid_o !== 1'b0) begin n_fail++; $display("FAIL late_ok_valid: got %b want 0", ifid_valid_o); end
        $display("test_reset done");
    endtask

    task automatic test_aligned();
        do_reset();
        pc_i = 32'hbfc0_0000; inst_addr_ok_i = 1; #1;
        n_assert++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'hbfc0_0000) begin n_fail++; $display("FAIL aligned_req: got req %b addr %h want 1 bfc00000", inst_req_o, inst_addr_o); end
        n_assert++; if (stallF_o !== 1'b1) begin n_fail++; $display("FAIL aligned_stall_c1: got %b want 1", stallF_o); end
        step();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 64'h1111_1111_2222_2222; #1;
        n_assert++; if (stallF_o !== 1'b0) begin n_fail++; $display("FAIL aligned_stall_c2: got %b want 0", stallF_o); end
        step();
        inst_data_ok_i = 0; pc_i = 32'hbfc0_0008; #1;
        n_assert++; if (ifid_valid_o !== 1'b1) begin n_fail++; $display("FAIL aligned_valid: got %b want 1", ifid_valid_o); end
        n_assert++; if (ifid_inst0_o !== 32'h2222_2222 || ifid_inst1_o !== 32'h1111_1111) begin n_fail++; $display("FAIL aligned_inst: got %h %h want 22222222 11111111", ifid_inst0_o, ifid_inst1_o); end
        n_assert++; if (ifid_inst1_valid_o !== 1'b1 || ifid_pc_o !== 32'hbfc0_0000) begin n_fail++; $display("FAIL aligned_pc: got v1 %b pc %h want 1 bfc00000", ifid_inst1_valid_o, ifid_pc_o); end
        n_assert++; if (stallF_o !== 1'b1) begin n_fail++; $display("FAIL aligned_stall_c3: got %b want 1", stallF_o); end
        $display("test_aligned done");
    endtask

    task automatic test_unaligned();
        do_reset();
        pc_i = 32'hbfc0_0004; inst_addr_ok_i = 1; #1;
        n_assert++; if (inst_addr_o !== 32'hbfc0_0000) begin n_fail++; $display("FAIL unaligned_addr: got %h want bfc00000", inst_addr_o); end
        step();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 64'haaaa_aaaa_bbbb_bbbb; step();
        inst_data_ok_i = 0; #1;
        n_assert++; if (ifid_inst0_o !== 32'haaaa_aaaa || ifid_inst1_valid_o !== 1'b0) begin n_fail++; $display("FAIL unaligned_inst: got %h v1 %b want aaaaaaaa 0", ifid_inst0_o, ifid_inst1_valid_o); end
        n_assert++; if (ifid_pc_o !== 32'hbfc0_0004) begin n_fail++; $display("FAIL unaligned_pc: got %h want bfc00004", ifid_pc_o); end
        $display("test_unaligned done");
    endtask

    task automatic test_cancel_data();
        do_reset();
        ifid_ready_i = 1; pc_i = 32'h1000; inst_addr_ok_i = 1; step();
        inst_addr_ok_i = 0; flush_i = 1; #1;
        n_assert++; if (stallF_o !== 1'b0) begin n_fail++; $display("FAIL cancel_flush_stall: got %b want 0", stallF_o); end
        step();
        flush_i = 0; pc_i = 32'h2000; #1;
        n_assert++; if (inst_req_o !== 1'b0) begin n_fail++; $display("FAIL cancel_req: got %b want 0", inst_req_o); end
        step();
        inst_data_ok_i = 1; inst_rdata_i = 64'h5555_5555_6666_6666; #1;
        n_assert++; if (stallF_o !== 1'b1) begin n_fail++; $display("FAIL cancel_discard_stall: got %b want 1", stallF_o); end
        step();
        inst_data_ok_i = 0; #1;
        n_assert++; if (ifid_valid_o !== 1'b0) begin n_fail++; $display("FAIL cancel_valid: got %b want 0", ifid_valid_o); end
        n_assert++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h2000) begin n_fail++; $display("FAIL cancel_new_addr: got req %b addr %h want 1 00002000", inst_req_o, inst_addr_o); end
        $display("test_cancel_data done");
    endtask

    task automatic test_held_addr();
        do_reset();
        pc_i = 32'h3000; flush_i = 1; #1;
        n_assert++; if (inst_addr_o !== 32'h3000) begin n_fail++; $display("FAIL held_addr_c0: got %h want 00003000", inst_addr_o); end
        step();
        pc_i = 32'h4000; flush_i = 0; #1;
        n_assert++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h3000) begin n_fail++; $display("FAIL held_addr_c1: got req %b addr %h want 1 00003000", inst_req_o, inst_addr_o); end
        step();
        pc_i = 32'h4000; flush_i = 1; #1;
        n_assert++; if (inst_addr_o !== 32'h3000) begin n_fail++; $display("FAIL held_addr_c2: got %h want 00003000", inst_addr_o); end
        step();
        pc_i = 32'h5000; flush_i = 0; inst_addr_ok_i = 1; #1;
        n_assert++; if (inst_addr_o !== 32'h3000) begin n_fail++; $display("FAIL held_addr_c3: got %h want 00003000", inst_addr_o); end
        step();
        inst_addr_ok_i = 0; step();
        inst_data_ok_i = 1; inst_rdata_i = 64'h7777_7777_8888_8888; #1;
        n_assert++; if (stallF_o !== 1'b1) begin n_fail++; $display("FAIL held_discard_stall: got %b want 1", stallF_o); end
        step();
        inst_data_ok_i = 0; #1;
        n_assert++; if (ifid_valid_o !== 1'b0 || inst_addr_o !== 32'h5000) begin n_fail++; $display("FAIL held_after: got valid %b addr %h want 0 00005000", ifid_valid_o, inst_addr_o); end
        $display("test_held_addr done");
    endtask

    task automatic test_skid();
        do_reset();
        ifid_ready_i = 0; pc_i = 32'h100; inst_addr_ok_i = 1; step();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 64'h0000_00a1_0000_00a0; step();
        inst_data_ok_i = 0; pc_i = 32'h108; inst_addr_ok_i = 1; step();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 64'h0000_00b1_0000_00b0; #1;
        n_assert++; if (stallF_o !== 1'b0) begin n_fail++; $display("FAIL skid_accept_stall: got %b want 0", stallF_o); end
        step();
        inst_data_ok_i = 0; pc_i = 32'h110; #1;
        n_assert++; if (inst_req_o !== 1'b0 || stallF_o !== 1'b1) begin n_fail++; $display("FAIL skid_full: got req %b stall %b want 0 1", inst_req_o, stallF_o); end
        n_assert++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h100 || ifid_inst0_o !== 32'ha0) begin n_fail++; $display("FAIL skid_hold_out: got v %b pc %h i0 %h want 1 00000100 000000a0", ifid_valid_o, ifid_pc_o, ifid_inst0_o); end
        step();
        n_assert++; if (inst_req_o !== 1'b0 || ifid_pc_o !== 32'h100) begin n_fail++; $display("FAIL skid_full_c2: got req %b pc %h want 0 00000100", inst_req_o, ifid_pc_o); end
        ifid_ready_i = 1; step();
        ifid_ready_i = 0; #1;
        n_assert++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h108 || ifid_inst0_o !== 32'hb0) begin n_fail++; $display("FAIL skid_drain: got v %b pc %h i0 %h want 1 00000108 000000b0", ifid_valid_o, ifid_pc_o, ifid_inst0_o); end
        n_assert++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h110) begin n_fail++; $display("FAIL skid_next_req: got req %b addr %h want 1 00000110", inst_req_o, inst_addr_o); end
        $display("test_skid done");
    endtask

    task automatic test_flush_vs_data();
        do_reset();
        pc_i = 32'h200; inst_addr_ok_i = 1; step();
        inst_addr_ok_i = 0; inst_data_ok_i = 1; flush_i = 1; inst_rdata_i = 64'h9999_9999_aaaa_aaaa; #1;
        n_assert++; if (stallF_o !== 1'b0) begin n_fail++; $display("FAIL fvd_stall: got %b want 0", stallF_o); end
        step();
        inst_data_ok_i = 0; flush_i = 0; pc_i = 32'h300; #1;
        n_assert++; if (ifid_valid_o !== 1'b0) begin n_fail++; $display("FAIL fvd_valid: got %b want 0", ifid_valid_o); end
        n_assert++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h300) begin n_fail++; $display("FAIL fvd_next: got req %b addr %h want 1 00000300", inst_req_o, inst_addr_o); end
`ifdef FETCH_PERF_EN
        n_assert++; if (perf_cancel_o !== 32'd1 || perf_fetch_o !== 32'd0) begin n_fail++; $display("FAIL fvd_perf: got cancel %0d fetch %0d want 1 0", perf_cancel_o, perf_fetch_o); end
`endif
        $display("test_flush_vs_data done");
    endtask

    task automatic test_random();
        pkt_t        q[$];
        pkt_t        np;
        logic [31:0] pc_reg, txn_pc;
        logic [63:0] rd;
        bit          txn_active, txn_acc, txn_clean, good, exp_stall, exp_req;
        int          lat, n_good, n_cancel, n_stall;
        do_reset();
        pc_reg = 32'h1000_0000; txn_active = 0; txn_acc = 0; txn_clean = 0; lat = 0;
        txn_pc = '0; n_good = 0; n_cancel = 0; n_stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pc_i           = pc_reg;
            flush_i        = ($urandom_range(0, 9) == 0);
            ifid_ready_i   = ($urandom_range(0, 3) != 0);
            inst_data_ok_i = txn_acc && (lat == 0);
            inst_addr_ok_i = inst_req_o && !txn_acc && ($urandom_range(0, 1) == 1);
            rd             = {$urandom, $urandom};
            inst_rdata_i   = rd;
            #1;
            exp_req = !txn_acc && (q.size() < 2);
            n_assert++; if (inst_req_o !== exp_req) begin n_fail++; $display("FAIL rnd_req cyc %0d: got %b want %b", cyc, inst_req_o, exp_req); end
            if (inst_req_o) begin
                if (!txn_active) begin txn_active = 1; txn_pc = pc_i; txn_clean = 1; end
                n_assert++; if (inst_addr_o !== (txn_pc & 32'hffff_fff8)) begin n_fail++; $display("FAIL rnd_addr cyc %0d: got %h want %h", cyc, inst_addr_o, txn_pc & 32'hffff_fff8); end
            end
            if (txn_active && flush_i) txn_clean = 0;
            good      = inst_data_ok_i && txn_clean && !flush_i;
            exp_stall = !(good || flush_i);
            n_assert++; if (stallF_o !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d: got %b want %b", cyc, stallF_o, exp_stall); end
            n_assert++; if (ifid_valid_o !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, ifid_valid_o, q.size() > 0); end
            if (q.size() > 0) begin
                n_assert++;
                if (ifid_pc_o !== q[0].pc || ifid_inst0_o !== q[0].i0 || ifid_inst1_o !== q[0].i1 || ifid_inst1_valid_o !== q[0].v1) begin
                    n_fail++;
                    $display("FAIL rnd_pkt cyc %0d: got %h %h %h %b want %h %h %h %b", cyc, ifid_pc_o, ifid_inst0_o,
                             ifid_inst1_o, ifid_inst1_valid_o, q[0].pc, q[0].i0, q[0].i1, q[0].v1);
                end
            end
            if (q.size() > 0 && ifid_ready_i) void'(q.pop_front());
            if (flush_i) q.delete();
            if (good) begin
                np.pc = txn_pc;
                np.i0 = txn_pc[2] ? rd[63:32] : rd[31:0];
                np.i1 = rd[63:32];
                np.v1 = !txn_pc[2];
                q.push_back(np);
            end
            n_good   += int'(good);
            n_cancel += int'(inst_data_ok_i && !good);
            n_stall  += int'(exp_stall);
            if (inst_data_ok_i) begin txn_active = 0; txn_acc = 0; end
            else if (txn_acc && lat > 0) lat--;
            if (inst_addr_ok_i) begin txn_acc = 1; lat = $urandom_range(0, 3); end
            if (flush_i) pc_reg = $urandom & 32'hffff_fffc;
            else if (!exp_stall) pc_reg = pc_reg + (pc_reg[2] ? 32'd4 : 32'd8);
            step();
        end
`ifdef FETCH_PERF_EN
        // the IDLE cycle after reset release is also a stall cycle
        n_assert++; if (perf_fetch_o !== n_good) begin n_fail++; $display("FAIL rnd_perf_fetch: got %0d want %0d", perf_fetch_o, n_good); end
        n_assert++; if (perf_cancel_o !== n_cancel) begin n_fail++; $display("FAIL rnd_perf_cancel: got %0d want %0d", perf_cancel_o, n_cancel); end
        n_assert++; if (perf_stall_o !== n_stall + 1) begin n_fail++; $display("FAIL rnd_perf_stall: got %0d want %0d", perf_stall_o, n_stall + 1); end
`endif
        $display("test_random done: %0d good responses, %0d discarded", n_good, n_cancel);
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_aligned();
        test_unaligned();
        test_cancel_data();
        test_held_addr();
        test_skid();
        test_flush_vs_data();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
